// File: rtl/alu_reg_sequencer_if.sv
// Command bus for the ALU register sequencer: one command per valid/ready handshake.
interface alu_reg_sequencer_if #(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
);
    localparam int AW = $clog2(NREG);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [3:0]       cmd_select;
    logic             cmd_mode;
    logic             cmd_cin;
    logic             cmd_use_carry;
    logic [AW-1:0]    cmd_rs;
    logic [AW-1:0]    cmd_rt;
    logic [AW-1:0]    cmd_rd;
    logic [WIDTH-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_select, cmd_mode, cmd_cin, cmd_use_carry,
               cmd_rs, cmd_rt, cmd_rd, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_select, cmd_mode, cmd_cin, cmd_use_carry,
               cmd_rs, cmd_rt, cmd_rd, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_reg_sequencer.sv
// Operand/write-back sequencer around an external combinational 74181-style ALU:
// latches operands from an 8-entry register file, then writes f/cout back one cycle later.
module alu_reg_sequencer #(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_reg_sequencer_if.slave       cmd,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_select,
    output logic                     alu_mode,
    output logic                     alu_cin,
    input  logic [WIDTH-1:0]         alu_f,
    input  logic                     alu_cout,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic                     carry_flag,
    output logic                     zero_flag,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] rf [NREG];
    logic             op_p1;
    logic [AW-1:0]    rd_p1;
    logic [WIDTH-1:0] imm_p1;
    logic [WIDTH-1:0] wb_val;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        cmd.cmd_ready  = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                cmd.cmd_ready = 1'b1;
                accept        = cmd.cmd_valid;
                if (cmd.cmd_valid) state_next = EXEC;
            end
            EXEC: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign wb_val = op_p1 ? imm_p1 : alu_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            alu_mode   <= 1'b0;
            alu_cin    <= 1'b0;
            op_p1      <= 1'b0;
            rd_p1      <= '0;
            imm_p1     <= '0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // Stage p1: operands read from the pre-write register file at the accept edge
            if (accept) begin
                alu_a      <= rf[cmd.cmd_rs];
                alu_b      <= rf[cmd.cmd_rt];
                alu_select <= cmd.cmd_select;
                alu_mode   <= cmd.cmd_mode;
                alu_cin    <= cmd.cmd_use_carry ? carry_flag : cmd.cmd_cin;
                op_p1      <= cmd.cmd_op;
                rd_p1      <= cmd.cmd_rd;
                imm_p1     <= cmd.cmd_imm;
            end
            // Write-back: ALU has settled during EXEC; load-immediate leaves carry alone
            if (state == EXEC) begin
                rf[rd_p1] <= wb_val;
                result    <= wb_val;
                zero_flag <= (wb_val == '0);
                if (!op_p1) carry_flag <= alu_cout;
                done      <= 1'b1;
            end
        end
    end

    assign dbg_data = rf[dbg_addr];
endmodule
